serial_dram_bridge: RTL and testbench

SERIAL_DRAM_BRIDGE -- requirements
Module: serial_dram_bridge

---
 rtl/serial_dram_bridge_if.sv | 30 +++
 rtl/serial_dram_bridge.sv | 170 +++++++++++++++++
 tb/tb_serial_dram_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_dram_bridge_if.sv
// Bundle of the serial byte streams and the memory request/return channel.
// The master modport is the bridge side; the slave modport is the environment side.
interface serial_dram_bridge_if #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4
) ();
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    mem_valid;
    logic                    mem_ready;
    logic                    mem_we;
    logic [ADDR_BYTES*8-1:0] mem_addr;
    logic [DATA_BYTES*8-1:0] mem_wdata;
    logic [DATA_BYTES*8-1:0] mem_rdata;
    logic                    mem_rvalid;

    modport master (
        input  rx_data, rx_valid, tx_ready, mem_ready, mem_rdata, mem_rvalid,
        output rx_ready, tx_data, tx_valid, mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, mem_ready, mem_rdata, mem_rvalid,
        input  rx_ready, tx_data, tx_valid, mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/serial_dram_bridge.sv
// Byte-serial command bridge: parses 'W'/'R' commands from the rx stream, issues one
// memory request and streams back an ACK, NAK or the little-endian read word on tx.
module serial_dram_bridge #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    serial_dram_bridge_if.master bus
);
    localparam int AW        = ADDR_BYTES * 8;
    localparam int DW        = DATA_BYTES * 8;
    localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CW        = $clog2(MAX_BYTES) + 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, WAIT_R, RESP} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [DW-1:0]  resp_q;
    logic [CW-1:0]  resp_last_q;
    logic           load_nak, load_ack, capture;
    logic           rx_fire, tx_fire, mem_fire;
    logic [7:0]     tx_byte;

    assign rx_fire  = bus.rx_valid && bus.rx_ready;
    assign tx_fire  = bus.tx_valid && bus.tx_ready;
    assign mem_fire = bus.mem_valid && bus.mem_ready;

    assign bus.rx_ready  = (state == IDLE) || (state == ADDR) || (state == WDATA);
    assign bus.tx_valid  = (state == RESP);
    assign bus.tx_data   = tx_byte;
    assign bus.mem_valid = (state == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_nak   = 1'b0;
        load_ack   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rx_fire) begin
                    if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) begin
                        state_next = ADDR;
                    end else begin
                        state_next = RESP;
                        load_nak   = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    if (cnt == ADDR_LAST) begin
                        cnt_next   = '0;
                        state_next = we_q ? WDATA : REQ;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (rx_fire) begin
                    if (cnt == DATA_LAST) begin
                        cnt_next   = '0;
                        state_next = REQ;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_fire) begin
                    if (we_q) begin
                        state_next = RESP;
                        load_ack   = 1'b1;
                    end else if (bus.mem_rvalid) begin
                        // Return arriving with acceptance skips the wait state.
                        state_next = RESP;
                        capture    = 1'b1;
                    end else begin
                        state_next = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (bus.mem_rvalid) begin
                    state_next = RESP;
                    capture    = 1'b1;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (cnt == resp_last_q) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            resp_last_q <= '0;
        end else begin
            if (state == IDLE && rx_fire) begin
                we_q <= (bus.rx_data == 8'h57);
            end
            if (state == ADDR && rx_fire) begin
                for (int i = 0; i < ADDR_BYTES; i++) begin
                    if (cnt == CW'(i)) addr_q[i*8 +: 8] <= bus.rx_data;
                end
            end
            if (state == WDATA && rx_fire) begin
                for (int i = 0; i < DATA_BYTES; i++) begin
                    if (cnt == CW'(i)) wdata_q[i*8 +: 8] <= bus.rx_data;
                end
            end
            if (load_nak) begin
                resp_q      <= DW'(8'h15);
                resp_last_q <= '0;
            end else if (load_ack) begin
                resp_q      <= DW'(8'h06);
                resp_last_q <= '0;
            end else if (capture) begin
                resp_q      <= bus.mem_rdata;
                resp_last_q <= DATA_LAST;
            end
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        if (state == RESP) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (cnt == CW'(i)) tx_byte = resp_q[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_serial_dram_bridge.sv
// Directed bench for serial_dram_bridge: write, read, NAK, stalled response,
// read-return bypass, stray return and mid-command reset.
module tb_serial_dram_bridge;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mem_valid_cycles = 0;
    int   snap;

    always #5 clk = ~clk;

    serial_dram_bridge_if #(.ADDR_BYTES(4), .DATA_BYTES(4)) bus ();

    serial_dram_bridge #(.ADDR_BYTES(4), .DATA_BYTES(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always @(posedge clk) if (bus.mem_valid) mem_valid_cycles++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rx_accept", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic sendCommand(input logic [7:0] cmd, input logic [31:0] addr);
        sendByte(cmd);
        for (int i = 0; i < 4; i++) sendByte(addr[i*8 +: 8]);
    endtask

    task automatic sendWrite(input logic [31:0] addr, input logic [31:0] data);
        sendCommand(8'h57, addr);
        for (int i = 0; i < 4; i++) sendByte(data[i*8 +: 8]);
    endtask

    task automatic waitMemValid(input string tag);
        int n;
        n = 0;
        while (!bus.mem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'd1);
    endtask

    task automatic collectResp(input string tag, input int nbytes, input logic [63:0] exp, input bit stall);
        int         n;
        bit         done;
        bit         held;
        logic [7:0] held_data;
        for (int k = 0; k < nbytes; k++) begin
            n = 0;
            done = 1'b0;
            held = 1'b0;
            held_data = 8'h00;
            while (!done && n < 200) begin
                bus.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!stall && k > 0 && n == 0) checkOutput({tag, "_rate"}, 64'(bus.tx_valid), 64'd1);
                if (bus.tx_valid) begin
                    checkOutput({tag, "_rx_ready_low"}, 64'(bus.rx_ready), 64'd0);
                    if (held) checkOutput({tag, "_stable"}, 64'(bus.tx_data), 64'(held_data));
                    if (bus.tx_ready) begin
                        checkOutput($sformatf("%s_byte%0d", tag, k), 64'(bus.tx_data), 64'(exp[k*8 +: 8]));
                        done = 1'b1;
                    end else begin
                        held = 1'b1;
                        held_data = bus.tx_data;
                    end
                end
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("%s_byte%0d_seen", tag, k), 64'(done), 64'd1);
        end
        bus.tx_ready = 1'b0;
        checkOutput({tag, "_idle_tx_valid"}, 64'(bus.tx_valid), 64'd0);
        checkOutput({tag, "_idle_rx_ready"}, 64'(bus.rx_ready), 64'd1);
    endtask

    task automatic acceptRequest();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        checkOutput("mem_valid_drop", 64'(bus.mem_valid), 64'd0);
    endtask

    task automatic applyStimulus();
        // Reset values, observed before any clock edge.
        #2;
        checkOutput("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        checkOutput("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        checkOutput("rst_tx_data", 64'(bus.tx_data), 64'd0);
        checkOutput("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Write with mem_ready held low for three cycles.
        sendWrite(32'h80000010, 32'hDEADBEEF);
        for (int c = 0; c < 4; c++) begin
            checkOutput("wr_mem_valid", 64'(bus.mem_valid), 64'd1);
            checkOutput("wr_mem_we", 64'(bus.mem_we), 64'd1);
            checkOutput("wr_mem_addr", 64'(bus.mem_addr), 64'h80000010);
            checkOutput("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
            checkOutput("wr_rx_ready", 64'(bus.rx_ready), 64'd0);
            if (c < 3) @(negedge clk);
        end
        acceptRequest();
        collectResp("wr", 1, 64'h06, 1'b0);

        // Read with the return five cycles after acceptance.
        sendCommand(8'h52, 32'h80000010);
        checkOutput("rd_mem_valid", 64'(bus.mem_valid), 64'd1);
        checkOutput("rd_mem_we", 64'(bus.mem_we), 64'd0);
        checkOutput("rd_mem_addr", 64'(bus.mem_addr), 64'h80000010);
        acceptRequest();
        repeat (4) begin
            checkOutput("rd_wait_tx_valid", 64'(bus.tx_valid), 64'd0);
            checkOutput("rd_wait_rx_ready", 64'(bus.rx_ready), 64'd0);
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h11223344;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        collectResp("rd", 4, 64'h11223344, 1'b0);

        // Unknown command byte, then a read with random tx stalls.
        snap = mem_valid_cycles;
        sendByte(8'h41);
        collectResp("nak", 1, 64'h15, 1'b0);
        checkOutput("nak_no_mem_valid", 64'(mem_valid_cycles - snap), 64'd0);
        sendCommand(8'h52, 32'h00000400);
        waitMemValid("stall");
        checkOutput("stall_mem_addr", 64'(bus.mem_addr), 64'h00000400);
        acceptRequest();
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55667788;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        collectResp("stall", 4, 64'h55667788, 1'b1);

        // Return in the acceptance cycle, then a stray return while idle.
        sendCommand(8'h52, 32'h00000020);
        waitMemValid("byp");
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        collectResp("byp", 4, 64'hCAFEF00D, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        repeat (3) begin
            checkOutput("stray_tx_valid", 64'(bus.tx_valid), 64'd0);
            @(negedge clk);
        end

        // Reset after two address bytes of a write.
        sendByte(8'h57);
        sendByte(8'h78);
        sendByte(8'h56);
        #2 nrst = 1'b0;
        #1;
        checkOutput("mid_rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        checkOutput("mid_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        checkOutput("mid_rst_tx_data", 64'(bus.tx_data), 64'd0);
        checkOutput("mid_rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        checkOutput("mid_rst_mem_we", 64'(bus.mem_we), 64'd0);
        checkOutput("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        checkOutput("mid_rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        sendWrite(32'h12345678, 32'hA5A55A5A);
        checkOutput("post_rst_mem_valid", 64'(bus.mem_valid), 64'd1);
        checkOutput("post_rst_mem_we", 64'(bus.mem_we), 64'd1);
        checkOutput("post_rst_mem_addr", 64'(bus.mem_addr), 64'h12345678);
        checkOutput("post_rst_mem_wdata", 64'(bus.mem_wdata), 64'hA5A55A5A);
        acceptRequest();
        collectResp("post_rst", 1, 64'h06, 1'b0);
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.tx_ready   = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
